// File: rtl/mac_vec_ctrl_pkg.sv
// Shared definitions for the dot-product MAC controller: FSM encoding and default widths.
package mac_vec_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int LEN     = 4;

endpackage

// File: rtl/mac_vec_ctrl_mac.sv
// Combinational MAC: out = a*b + c with unsigned a, signed b, modulo 2^psum_bw.
module mac_vec_ctrl_mac
  import mac_vec_ctrl_pkg::*;
#(
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW
) (
  input  logic        [bw-1:0]      a,
  input  logic signed [bw-1:0]      b,
  input  logic signed [psum_bw-1:0] c,
  output logic signed [psum_bw-1:0] out
);

  logic signed [psum_bw-1:0] a_x;
  logic signed [psum_bw-1:0] b_x;
  logic signed [psum_bw-1:0] prod;

  // Widen both operands to psum_bw first; the true product always fits, so
  // the low psum_bw bits of the multiply are already the sign-extended result.
  assign a_x  = {{(psum_bw-bw){1'b0}}, a};
  assign b_x  = {{(psum_bw-bw){b[bw-1]}}, b};
  assign prod = a_x * b_x;
  assign out  = c + prod;

endmodule

// File: rtl/mac_vec_ctrl.sv
// Sequences len (activation, weight) pairs through the MAC on top of an initial
// psum and holds the finished dot product until the consumer takes it.
module mac_vec_ctrl
  import mac_vec_ctrl_pkg::*;
#(
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int len     = LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_a,
  input  logic [bw-1:0]      in_b,
  input  logic [psum_bw-1:0] in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum,
  output logic               busy
);

  localparam int CNT_W = $clog2(len + 1);

  state_t                    state;
  state_t                    state_nxt;
  logic signed [psum_bw-1:0] acc;
  logic signed [psum_bw-1:0] mac_c;
  logic signed [psum_bw-1:0] mac_out;
  logic [CNT_W-1:0]          cnt;
  logic                      accept;
  logic                      last;

  assign in_ready = (state != HOLD);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (state == IDLE) ? (len == 1) : (cnt == CNT_W'(len - 1));
  // The initial psum only enters on the first pair; afterwards the MAC chains on acc.
  assign mac_c    = (state == IDLE) ? signed'(in_c) : acc;

  mac_vec_ctrl_mac #(
    .bw      (bw),
    .psum_bw (psum_bw)
  ) u_mac (
    .a   (in_a),
    .b   (signed'(in_b)),
    .c   (mac_c),
    .out (mac_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = last ? HOLD : ACC;
      ACC:     if (in_valid && last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, element counter and held result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_psum  <= '0;
    end else begin
      if (accept) begin
        acc <= mac_out;
        if (last) begin
          cnt       <= '0;
          out_psum  <= mac_out;
          out_valid <= 1'b1;
        end else begin
          cnt <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
        end
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_ctrl.sv
// Directed-vector bench for mac_vec_ctrl with hand-computed dot products.
module tb_mac_vec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [15:0] in_c;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_psum;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mac_vec_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_psum  (out_psum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds one 4-pair vector; returns #1 after the edge that accepted the last pair.
  task automatic run_vec(input logic [15:0] c,
                         input logic [3:0] a0, a1, a2, a3,
                         input logic [3:0] b0, b1, b2, b3,
                         input bit bub);
    logic [3:0] va[4];
    logic [3:0] vb[4];
    int n;
    va = '{a0, a1, a2, a3};
    vb = '{b0, b1, b2, b3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = va[i];
      in_b     = vb[i];
      in_c     = (i == 0) ? c : 16'h5555;
      n = 0;
      while (!in_ready && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) chk("accept_tmo", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      if (bub && i < 3) begin
        chk("bubble_busy", {31'd0, busy}, 32'd1);
        chk("bubble_noout", {31'd0, out_valid}, 32'd0);
        step();
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c      = '0;
    out_ready = 1'b1;

    // Asynchronous reset asserted mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_psum", {16'd0, out_psum}, 32'h0000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // 1*1 + 2*-1 + 3*2 + 4*-2 = -3
    run_vec(16'h0000, 4'd1, 4'd2, 4'd3, 4'd4, 4'h1, 4'hF, 4'h2, 4'hE, 1'b0);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_psum", {16'd0, out_psum}, 32'hFFFD);
    chk("b2b_hold_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("b2b_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("b2b_psum_kept", {16'd0, out_psum}, 32'hFFFD);
    chk("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);

    // 100 + 4 * (15 * -8) = -380
    run_vec(16'd100, 4'd15, 4'd15, 4'd15, 4'd15, 4'h8, 4'h8, 4'h8, 4'h8, 1'b0);
    chk("ext_valid", {31'd0, out_valid}, 32'd1);
    chk("ext_psum", {16'd0, out_psum}, 32'hFE84);
    step();

    // -16 + 105 = 89
    run_vec(16'hFFF0, 4'd15, 4'd0, 4'd5, 4'd0, 4'h7, 4'h3, 4'h0, 4'h0, 1'b0);
    chk("wrap_psum", {16'd0, out_psum}, 32'h0059);
    step();

    // Bubbles between pairs, then three cycles of backpressure
    out_ready = 1'b0;
    run_vec(16'h0000, 4'd1, 4'd2, 4'd3, 4'd4, 4'h1, 4'hF, 4'h2, 4'hE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_psum", {16'd0, out_psum}, 32'hFFFD);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_xfer_busy", {31'd0, busy}, 32'd0);

    // Partial vector discarded by reset
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'h3; in_c = 16'h0100;
    step();
    in_a = 4'd5; in_b = 4'h2;
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_psum", {16'd0, out_psum}, 32'h0000);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
    end
    run_vec(16'h0000, 4'd1, 4'd2, 4'd3, 4'd4, 4'h1, 4'hF, 4'h2, 4'hE, 1'b0);
    chk("fresh_valid", {31'd0, out_valid}, 32'd1);
    chk("fresh_psum", {16'd0, out_psum}, 32'hFFFD);
    step();
    chk("fresh_done", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
